// File: rtl/lint_arb_pkg.sv
// -----------------------------------------------------------------------------
// lint_arb_pkg
// Shared types and helpers for the lint-to-AXI round-robin arbiter.
//   arb_state_e : arbiter FSM states
//   idx_w()     : width of a master index. The package cannot see the top-level
//                 N_MASTERS parameter, so each user derives its own
//                 IDX_W = idx_w(N_MASTERS).
// -----------------------------------------------------------------------------
package lint_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // free: pick a winner and present it to the bridge
        HOLD  = 2'd1,   // request presented, waiting for bridge grant
        BUSY  = 2'd2,   // granted, waiting for bridge response
        DRAIN = 2'd3    // watchdog fired, swallow the late bridge response
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lint_rr_sel.sv
// -----------------------------------------------------------------------------
// lint_rr_sel
// Combinational round-robin priority picker. Scans i_req starting at i_ptr
// upward, wrapping at N_MASTERS, and returns the first requester found.
// Ports:
//   i_req   : per-master request vector
//   i_ptr   : index of the highest-priority master this cycle
//   o_valid : at least one request is set
//   o_idx   : winning master index (0 when o_valid is low)
// -----------------------------------------------------------------------------
module lint_rr_sel #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [N_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_idx
);

    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        o_valid = 1'b0;
        o_idx   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            // i_ptr < N_MASTERS and k < N_MASTERS, so one subtraction wraps
            pos = int'(i_ptr) + k;
            if (pos >= N_MASTERS) begin
                pos = pos - N_MASTERS;
            end
            pos_idx = IDX_W'(pos);
            if (!o_valid && i_req[pos_idx]) begin
                o_valid = 1'b1;
                o_idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/lint_2_axi_arbiter.sv
// -----------------------------------------------------------------------------
// lint_2_axi_arbiter
// Shares one single-outstanding lint-to-AXI bridge between N_MASTERS lint
// masters. A round-robin winner is presented to the bridge; once presented the
// selection is frozen until the bridge grants (the bridge may already have
// issued AW/AR). The granted master becomes the owner and alone receives the
// response. A watchdog answers the owner with an error if the bridge stays
// silent for TIMEOUT_CYCLES cycles (0 disables it); the late response is then
// swallowed.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   m_*_i                   : per-master lint request channel (packed arrays)
//   m_gnt_o, m_rvalid_o     : one-hot grant / response valid
//   m_rdata_o ... m_raux_o  : broadcast response payload (0 when idle)
//   s_*_o                   : request channel to the bridge
//   s_gnt_i, s_r*_i         : bridge grant and response channel
//   timeout_o               : one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module lint_2_axi_arbiter
    import lint_arb_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int BE_WIDTH       = 4,
    parameter int ID_WIDTH       = 16,
    parameter int AUX_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_MASTERS-1:0]                 m_req_i,
    input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
    input  logic [N_MASTERS-1:0]                 m_we_i,
    input  logic [N_MASTERS-1:0][31:0]           m_wdata_i,
    input  logic [N_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i,
    input  logic [N_MASTERS-1:0][ID_WIDTH-1:0]   m_ID_i,
    input  logic [N_MASTERS-1:0][AUX_WIDTH-1:0]  m_aux_i,
    output logic [N_MASTERS-1:0]                 m_gnt_o,
    output logic [N_MASTERS-1:0]                 m_rvalid_o,
    output logic [31:0]                          m_rdata_o,
    output logic                                 m_ropc_o,
    output logic [ID_WIDTH-1:0]                  m_rID_o,
    output logic [AUX_WIDTH-1:0]                 m_raux_o,
    output logic                                 s_req_o,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic                                 s_we_o,
    output logic [31:0]                          s_wdata_o,
    output logic [BE_WIDTH-1:0]                  s_be_o,
    output logic [ID_WIDTH-1:0]                  s_ID_o,
    output logic [AUX_WIDTH-1:0]                 s_aux_o,
    input  logic                                 s_gnt_i,
    input  logic                                 s_rvalid_i,
    input  logic [31:0]                          s_rdata_i,
    input  logic                                 s_ropc_i,
    input  logic [ID_WIDTH-1:0]                  s_rID_i,
    input  logic [AUX_WIDTH-1:0]                 s_raux_i,
    output logic                                 timeout_o
);

    localparam int IDX_W = idx_w(N_MASTERS);

    arb_state_e           r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_sel;
    logic [31:0]          r_wdog;
    logic [ID_WIDTH-1:0]  r_id;
    logic [AUX_WIDTH-1:0] r_aux;

    logic                 w_win_vld;
    logic [IDX_W-1:0]     w_win_idx;
    logic [IDX_W-1:0]     w_cur_idx;
    logic [IDX_W-1:0]     w_next_ptr;
    logic                 w_active;
    logic                 w_grant;
    logic                 w_wdog_hit;

    lint_rr_sel #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_rr_sel (
        .i_req   (m_req_i),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_win_vld),
        .o_idx   (w_win_idx)
    );

    // Stage: request selection (IDLE picks live, HOLD replays the frozen pick)
    always_comb begin
        w_cur_idx  = (r_state == HOLD) ? r_sel : w_win_idx;
        w_active   = ((r_state == IDLE) && w_win_vld) || (r_state == HOLD);
        w_grant    = w_active && s_gnt_i;
        w_next_ptr = (w_cur_idx == IDX_W'(N_MASTERS - 1)) ? '0 : w_cur_idx + IDX_W'(1);
        // A real response in the timeout cycle takes precedence
        w_wdog_hit = (TIMEOUT_CYCLES != 0) && (r_state == BUSY) && !s_rvalid_i &&
                     (r_wdog == 32'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        s_req_o   = w_active;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_wdata_o = '0;
        s_be_o    = '0;
        s_ID_o    = '0;
        s_aux_o   = '0;
        m_gnt_o   = '0;
        if (w_active) begin
            s_addr_o  = m_addr_i[w_cur_idx];
            s_we_o    = m_we_i[w_cur_idx];
            s_wdata_o = m_wdata_i[w_cur_idx];
            s_be_o    = m_be_i[w_cur_idx];
            s_ID_o    = m_ID_i[w_cur_idx];
            s_aux_o   = m_aux_i[w_cur_idx];
        end
        if (w_grant) begin
            m_gnt_o[w_cur_idx] = 1'b1;
        end
    end

    // Stage: response routing to the owner
    always_comb begin
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_ropc_o   = 1'b0;
        m_rID_o    = '0;
        m_raux_o   = '0;
        timeout_o  = 1'b0;
        if (r_state == BUSY) begin
            if (s_rvalid_i) begin
                m_rvalid_o[r_owner] = 1'b1;
                m_rdata_o           = s_rdata_i;
                m_ropc_o            = s_ropc_i;
                m_rID_o             = s_rID_i;
                m_raux_o            = s_raux_i;
            end else if (w_wdog_hit) begin
                m_rvalid_o[r_owner] = 1'b1;
                m_ropc_o            = 1'b1;
                m_rID_o             = r_id;
                m_raux_o            = r_aux;
                timeout_o           = 1'b1;
            end
        end
    end

    // Stage: arbiter state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_sel    <= '0;
            r_wdog   <= '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_grant) begin
                        r_owner  <= w_cur_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_wdog   <= '0;
                        r_state  <= BUSY;
                    end else if ((r_state == IDLE) && w_win_vld) begin
                        r_sel   <= w_win_idx;
                        r_state <= HOLD;
                    end
                end
                BUSY: begin
                    r_wdog <= r_wdog + 32'd1;
                    if (s_rvalid_i) begin
                        r_state <= IDLE;
                    end else if (w_wdog_hit) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // ID/aux of the granted request, replayed in a watchdog error response
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_id  <= m_ID_i[w_cur_idx];
            r_aux <= m_aux_i[w_cur_idx];
        end
    end

    // A lint master must keep req high until it sees gnt
    a_hold_req_stable: assert property (
        @(posedge clk_i) disable iff (rst_i) (r_state == HOLD) |-> m_req_i[r_sel]
    );

endmodule
